// File: rtl/merge_stage_pkg.sv
// rtl/merge_stage_pkg.sv - shared lane-index constants and width default for the join stage
package merge_stage_pkg;
  localparam int WIDTH_DEF = 32;
  localparam logic LANE1 = 1'b0;
  localparam logic LANE2 = 1'b1;
endpackage

// File: rtl/merge_skid.sv
// rtl/merge_skid.sv - one-entry skid register presenting a lane's candidate word to the arbiter
module merge_skid
  import merge_stage_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             v_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             grant,
  output logic             v_o,
  output logic [WIDTH-1:0] data_o,
  output logic             stall_o
);

  logic             skid_v;
  logic [WIDTH-1:0] skid_data;

  // A live input word that is not granted is parked here, so upstream sees stall only a cycle later.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      skid_v    <= 1'b0;
      skid_data <= '0;
    end else if (skid_v) begin
      if (grant) skid_v <= 1'b0;
    end else if (v_i && !grant) begin
      skid_v    <= 1'b1;
      skid_data <= data_i;
    end
  end

  assign v_o     = skid_v | v_i;
  assign data_o  = skid_v ? skid_data : data_i;
  assign stall_o = skid_v;

endmodule

// File: rtl/merge_stage.sv
// rtl/merge_stage.sv - two-into-one join stage with registered output and skid-buffered stalls
// MERGE_FAIR_EN selects round-robin arbitration; otherwise lane 1 has fixed priority.
module merge_stage
  import merge_stage_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             v_i1,
  input  logic [WIDTH-1:0] data_i1,
  output logic             stall_o1,
  input  logic             v_i2,
  input  logic [WIDTH-1:0] data_i2,
  output logic             stall_o2,
  output logic             v_o,
  output logic [WIDTH-1:0] data_o,
  output logic             src_o,
  input  logic             stall_i
);

  logic             cand_v1, cand_v2;
  logic [WIDTH-1:0] cand_d1, cand_d2;
  logic             accept, any_v, grant;
  logic             grant1, grant2;

  merge_skid #(.WIDTH(WIDTH)) u_skid1 (
    .clk(clk), .reset(reset), .v_i(v_i1), .data_i(data_i1), .grant(grant1),
    .v_o(cand_v1), .data_o(cand_d1), .stall_o(stall_o1)
  );

  merge_skid #(.WIDTH(WIDTH)) u_skid2 (
    .clk(clk), .reset(reset), .v_i(v_i2), .data_i(data_i2), .grant(grant2),
    .v_o(cand_v2), .data_o(cand_d2), .stall_o(stall_o2)
  );

  // An empty output register always takes a word, even while downstream stalls.
  assign accept = ~v_o | ~stall_i;
  assign any_v  = cand_v1 | cand_v2;

`ifdef MERGE_FAIR_EN
  logic prio_r;

  always_comb begin
    grant = LANE1;
    if (cand_v1 && cand_v2) grant = prio_r;
    else if (cand_v2)       grant = LANE2;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)               prio_r <= LANE1;
    else if (accept && any_v) prio_r <= ~grant;
  end
`else
  always_comb begin
    grant = cand_v1 ? LANE1 : LANE2;
  end
`endif

  assign grant1 = accept & cand_v1 & (grant == LANE1);
  assign grant2 = accept & cand_v2 & (grant == LANE2);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v_o    <= 1'b0;
      data_o <= '0;
      src_o  <= LANE1;
    end else if (accept) begin
      if (any_v) begin
        v_o    <= 1'b1;
        data_o <= (grant == LANE2) ? cand_d2 : cand_d1;
        src_o  <= grant;
      end else begin
        v_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_merge_stage.sv
// tb/tb_merge_stage.sv - randomized and directed scoreboard bench for merge_stage
module tb_merge_stage;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         reset;
  logic         v_i1, v_i2, stall_o1, stall_o2;
  logic [W-1:0] data_i1, data_i2;
  logic         v_o, src_o, stall_i;
  logic [W-1:0] data_o;

  always #5 clk = ~clk;

  merge_stage #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset),
    .v_i1(v_i1), .data_i1(data_i1), .stall_o1(stall_o1),
    .v_i2(v_i2), .data_i2(data_i2), .stall_o2(stall_o2),
    .v_o(v_o), .data_o(data_o), .src_o(src_o), .stall_i(stall_i)
  );

  int checks = 0;
  int errors = 0;
  logic [W-1:0] q1[$], q2[$];
  logic [W:0]   feed1[$], feed2[$];
  bit           took1 = 1'b0, took2 = 1'b0;
  logic [W-1:0] held;
  logic [W-1:0] exp_src;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Scoreboard push: a word is handed over whenever valid is high and the lane is not stalled.
  always @(negedge clk) begin
    took1 = reset && v_i1 && !stall_o1;
    took2 = reset && v_i2 && !stall_o2;
    if (took1) q1.push_back(data_i1);
    if (took2) q2.push_back(data_i2);
  end

  // Monitor: each consumed output word must be the oldest outstanding word of its lane.
  always @(negedge clk) begin
    if (reset && v_o && !stall_i) begin
      if (src_o == 1'b0) begin
        if (q1.size() == 0) begin
          checks++; errors++;
          $display("FAIL lane1_extra_word: got %0h expected no lane1 word", data_o);
        end else chk("lane1_order", data_o, q1.pop_front());
      end else begin
        if (q2.size() == 0) begin
          checks++; errors++;
          $display("FAIL lane2_extra_word: got %0h expected no lane2 word", data_o);
        end else chk("lane2_order", data_o, q2.pop_front());
      end
    end
  end

  task automatic drive();
    logic [W:0] e;
    if (!(v_i1 && !took1)) begin
      if (feed1.size() > 0) begin e = feed1.pop_front(); v_i1 = e[W]; data_i1 = e[W-1:0]; end
      else v_i1 = 1'b0;
    end
    if (!(v_i2 && !took2)) begin
      if (feed2.size() > 0) begin e = feed2.pop_front(); v_i2 = e[W]; data_i2 = e[W-1:0]; end
      else v_i2 = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic drain(input int n);
    stall_i = 1'b0;
    repeat (n) tick();
    chk("lane1_all_delivered", W'(q1.size() + feed1.size()), 0);
    chk("lane2_all_delivered", W'(q2.size() + feed2.size()), 0);
    chk("idle_v_o", v_o, 0);
  endtask

  initial begin
    reset = 1'b0; v_i1 = 1'b0; v_i2 = 1'b0; data_i1 = '0; data_i2 = '0; stall_i = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_v_o", v_o, 0);
    chk("rst_data_o", data_o, 0);
    chk("rst_src_o", src_o, 0);
    chk("rst_stall_o1", stall_o1, 0);
    chk("rst_stall_o2", stall_o2, 0);
    reset = 1'b1;

    for (int i = 0; i < 3; i++) feed1.push_back({1'b1, W'(32'h11 + i)});
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("l1_v_o", v_o, 1);
      chk("l1_data_o", data_o, W'(32'h11 + i));
      chk("l1_src_o", src_o, 0);
      chk("l1_stall_o1", stall_o1, 0);
    end
    drain(4);

    feed1.push_back({1'b1, W'(32'hA1)});
    feed2.push_back({1'b1, W'(32'hB2)});
    tick();
    tick();
    chk("col_first_data", data_o, 32'hA1);
    chk("col_first_src", src_o, 0);
    chk("col_stall_o2_high", stall_o2, 1);
    tick();
    chk("col_second_data", data_o, 32'hB2);
    chk("col_second_src", src_o, 1);
    chk("col_stall_o2_low", stall_o2, 0);
    drain(4);

    for (int i = 0; i < 6; i++) begin
      feed1.push_back({1'b1, W'(32'h60 + i)});
      feed2.push_back({1'b1, W'(32'h70 + i)});
    end
    tick();
    for (int i = 0; i < 6; i++) begin
      tick();
`ifdef MERGE_FAIR_EN
      exp_src = W'(i % 2);
`else
      exp_src = '0;
`endif
      chk("arb_v_o", v_o, 1);
      chk("arb_src_o", src_o, exp_src);
    end
    drain(20);

    for (int i = 0; i < 4; i++) begin
      feed1.push_back({1'b1, W'(32'h81 + i)});
      feed2.push_back({1'b1, W'(32'h91 + i)});
    end
    tick();
    tick();
    stall_i = 1'b1;
    held = data_o;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_v_o", v_o, 1);
      chk("stall_data_hold", data_o, held);
    end
    chk("stall_o1_full", stall_o1, 1);
    chk("stall_o2_full", stall_o2, 1);
    drain(20);

    stall_i = 1'b1;
    tick();
    chk("bub_empty", v_o, 0);
    feed2.push_back({1'b1, W'(32'hC3)});
    tick();
    tick();
    chk("bub_v_o", v_o, 1);
    chk("bub_src_o", src_o, 1);
    chk("bub_data_o", data_o, 32'hC3);
    drain(4);

    for (int c = 0; c < 600; c++) begin
      if (feed1.size() < 2) feed1.push_back({1'($urandom_range(0, 3) != 0), W'($urandom)});
      if (feed2.size() < 2) feed2.push_back({1'($urandom_range(0, 3) != 0), W'($urandom)});
      stall_i = ($urandom_range(0, 3) == 0);
      tick();
    end
    drain(20);

    for (int i = 0; i < 4; i++) begin
      feed1.push_back({1'b1, W'(32'hD0 + i)});
      feed2.push_back({1'b1, W'(32'hE0 + i)});
    end
    tick();
    tick();
    stall_i = 1'b1;
    tick();
    tick();
    chk("pre_rst_stall_o1", stall_o1, 1);
    chk("pre_rst_stall_o2", stall_o2, 1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_v_o", v_o, 0);
    chk("async_rst_data_o", data_o, 0);
    chk("async_rst_stall_o1", stall_o1, 0);
    chk("async_rst_stall_o2", stall_o2, 0);
    q1.delete(); q2.delete(); feed1.delete(); feed2.delete();
    v_i1 = 1'b0; v_i2 = 1'b0; stall_i = 1'b0;
    @(posedge clk);
    #3 reset = 1'b1;
    repeat (3) tick();
    chk("post_rst_dropped", v_o, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
